// File: rtl/uart_frame_ctrl.sv
// UART byte-stream framer: SYNC/ADDR/LEN/payload frames become memory writes through a small FIFO.
// Optional checksum byte after the payload is enabled by defining UART_FRAME_CHECKSUM_EN.
module uart_frame_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_done,
  input  logic [7:0]        rx_byte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ready,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]  SyncByte = 8'hA5;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StAddr  = 3'd1;
  localparam logic [2:0] StLen   = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StDrain = 3'd5;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] StChk   = 3'd4;
  localparam logic [2:0] StAfterData = StChk;
`else
  localparam logic [2:0] StAfterData = StDrain;
`endif

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [ToW-1:0]    r_to_cnt;
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_fifo_cnt;
  logic              r_frame_done;
  logic              r_frame_err;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]        r_xor;
  logic              r_chk_bad;
`endif

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_overflow;
  logic w_timeout;
  logic w_abort;
  logic w_push_ok;

  always_comb begin
    w_push     = rx_done && (r_state == StData);
    w_pop      = wr_en && wr_ready;
    w_full     = (r_fifo_cnt == CntW'(FIFO_DEPTH));
    w_overflow = w_push && w_full && !w_pop;
    w_timeout  = (r_state != StIdle) && (r_to_cnt == ToW'(TIMEOUT_CYC));
    w_abort    = w_overflow || w_timeout;
    w_push_ok  = w_push && !w_abort;
  end

  assign wr_en      = (r_fifo_cnt != '0);
  assign wr_data    = wr_en ? r_fifo[r_rd_ptr] : 8'h00;
  assign wr_addr    = r_addr;
  assign busy       = (r_state != StIdle);
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_len        <= '0;
      r_to_cnt     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      r_xor        <= '0;
      r_chk_bad    <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;

      if (r_state == StIdle || rx_done) begin
        r_to_cnt <= '0;
      end else if (!w_timeout) begin
        r_to_cnt <= r_to_cnt + ToW'(1);
      end

      // Accepted writes always advance the address, even in the cycle a frame aborts.
      if (r_state == StAddr && rx_done) begin
        r_addr <= ADDR_W'(rx_byte);
      end else if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      if (w_abort) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_fifo_cnt <= '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_fifo_cnt <= r_fifo_cnt + CntW'(w_push_ok) - CntW'(w_pop);
      end

      if (w_abort) begin
        r_state     <= StIdle;
        r_frame_err <= 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            if (rx_done && rx_byte == SyncByte) r_state <= StAddr;
`ifdef UART_FRAME_CHECKSUM_EN
            r_chk_bad <= 1'b0;
`endif
          end
          StAddr: begin
            if (rx_done) begin
              r_state <= StLen;
`ifdef UART_FRAME_CHECKSUM_EN
              r_xor   <= rx_byte;
`endif
            end
          end
          StLen: begin
            if (rx_done) begin
              r_len   <= rx_byte;
              r_state <= (rx_byte == 8'h00) ? StAfterData : StData;
`ifdef UART_FRAME_CHECKSUM_EN
              r_xor   <= r_xor ^ rx_byte;
`endif
            end
          end
          StData: begin
            if (rx_done) begin
              r_len <= r_len - 8'd1;
              if (r_len == 8'd1) r_state <= StAfterData;
`ifdef UART_FRAME_CHECKSUM_EN
              r_xor <= r_xor ^ rx_byte;
`endif
            end
          end
`ifdef UART_FRAME_CHECKSUM_EN
          StChk: begin
            if (rx_done) begin
              r_chk_bad <= (r_xor != rx_byte);
              r_state   <= StDrain;
            end
          end
`endif
          StDrain: begin
            // Bytes arriving here are dropped; finish once every payload byte is written.
            if (r_fifo_cnt == '0) begin
              r_state <= StIdle;
`ifdef UART_FRAME_CHECKSUM_EN
              if (r_chk_bad) r_frame_err  <= 1'b1;
              else           r_frame_done <= 1'b1;
`else
              r_frame_done <= 1'b1;
`endif
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Directed bench for uart_frame_ctrl: expected writes are queued as frames are sent and
// matched against writes captured from the write port.
module tb_uart_frame_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned TO    = 64;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_done;
  logic [7:0]    rx_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_ready;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_done    (rx_done),
    .rx_byte    (rx_byte),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  logic [AW+7:0] exp_q [$];
  logic [AW+7:0] obs_q [$];
  int n_done  = 0;
  int n_err   = 0;
  int n_clash = 0;
  int errors  = 0;
  int checks  = 0;
  logic [7:0] pl [8];

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (wr_en && wr_ready) obs_q.push_back({wr_addr, wr_data});
    if (frame_done) n_done++;
    if (frame_err) n_err++;
    if (frame_done && frame_err) n_clash++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_done = 1'b1;
    rx_byte = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
    rx_byte = 8'h00;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame(input logic [7:0] a, input int n, input int gap, input bit expect_wr);
    logic [AW-1:0] ad;
    logic [7:0]    x;
    ad = AW'(a);
    x  = a ^ 8'(n);
    send(8'hA5, gap);
    send(a, gap);
    send(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send(pl[i], gap);
      x = x ^ pl[i];
      if (expect_wr) exp_q.push_back({ad, pl[i]});
      ad = ad + AW'(1);
    end
`ifdef UART_FRAME_CHECKSUM_EN
    send(x, gap);
`endif
  endtask

  task automatic wait_quiet(input string tag);
    int cyc;
    cyc = 0;
    while ((busy || wr_en) && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " timeout"}, 32'(cyc >= 300), 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, " write count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check({tag, " write"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int d0;
    int e0;
    rst_n    = 1'b0;
    rx_done  = 1'b0;
    rx_byte  = 8'h00;
    wr_ready = 1'b1;
    #1;
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    check("reset wr_data", 32'(wr_data), 32'd0);
    check("reset pulses", 32'({frame_done, frame_err}), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame, spaced bytes
    d0 = n_done; e0 = n_err;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    frame(8'h10, 3, 2, 1'b1);
    wait_quiet("basic");
    compare_writes("basic");
    check("basic done", 32'(n_done - d0), 32'd1);
    check("basic err", 32'(n_err - e0), 32'd0);

    // Leading junk, back-to-back bytes (push and pop together), address wrap
    d0 = n_done; e0 = n_err;
    send(8'h00, 1);
    send(8'hFF, 1);
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    frame(8'hFE, 2, 0, 1'b1);
    wait_quiet("wrap");
    compare_writes("wrap");
    check("wrap done", 32'(n_done - d0), 32'd1);
    check("wrap addr", 32'(wr_addr), 32'd0);

    // Fill the FIFO exactly to depth while stalled: no overflow
    d0 = n_done; e0 = n_err;
    wr_ready = 1'b0;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    frame(8'h40, 4, 1, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("full wr_en", 32'(wr_en), 32'd1);
    check("full busy", 32'(busy), 32'd1);
    check("full no err", 32'(n_err - e0), 32'd0);
    wr_ready = 1'b1;
    wait_quiet("full");
    compare_writes("full");
    check("full done", 32'(n_done - d0), 32'd1);

    // Overflow: stalled target, six payload bytes into a four-deep FIFO
    d0 = n_done; e0 = n_err;
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) pl[i] = 8'hC1 + 8'(i);
    frame(8'h50, 6, 1, 1'b0);
    wait_quiet("ovf");
    check("ovf err", 32'(n_err - e0), 32'd1);
    check("ovf done", 32'(n_done - d0), 32'd0);
    check("ovf flushed", 32'(wr_en), 32'd0);
    wr_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    compare_writes("ovf");

    // Inactivity timeout after ADDR
    d0 = n_done; e0 = n_err;
    send(8'hA5, 0);
    send(8'h20, 0);
    repeat (TO - 4) begin
      @(posedge clk); #1;
    end
    check("to early busy", 32'(busy), 32'd1);
    check("to early err", 32'(n_err - e0), 32'd0);
    wait_quiet("to");
    check("to err", 32'(n_err - e0), 32'd1);
    check("to busy", 32'(busy), 32'd0);
    compare_writes("to");

`ifdef UART_FRAME_CHECKSUM_EN
    // Bad checksum: payload still written, then error instead of done
    d0 = n_done; e0 = n_err;
    send(8'hA5, 2); send(8'h00, 2); send(8'h01, 2); send(8'h55, 2); send(8'hFF, 2);
    exp_q.push_back({AW'(8'h00), 8'h55});
    wait_quiet("chk");
    compare_writes("chk");
    check("chk err", 32'(n_err - e0), 32'd1);
    check("chk done", 32'(n_done - d0), 32'd0);
`endif

    // Reset mid-DATA, then a normal frame
    d0 = n_done; e0 = n_err;
    wr_ready = 1'b0;
    send(8'hA5, 1); send(8'h30, 1); send(8'h04, 1); send(8'h01, 1); send(8'h02, 1);
    check("pre-rst wr_en", 32'(wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst wr_en", 32'(wr_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst addr/data", 32'({wr_addr, wr_data}), 32'd0);
    check("rst pulses", 32'({frame_done, frame_err}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_ready = 1'b1;
    check("rst no err", 32'(n_err - e0), 32'd0);
    pl[0] = 8'h5A; pl[1] = 8'h6B;
    frame(8'h70, 2, 1, 1'b1);
    wait_quiet("post-rst");
    compare_writes("post-rst");
    check("post-rst done", 32'(n_done - d0), 32'd1);
    check("post-rst err", 32'(n_err - e0), 32'd0);
    check("no done/err clash", 32'(n_clash), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
